// File: rtl/flash_dspi_responder.sv
// Target side of a dual-IO serial-flash link: answers 0xBB fast-read-dual-IO
// (with continuous-read mode) and 0x9F JEDEC ID, fetching bytes from an external memory.
module flash_dspi_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cs_n,
  input  logic [1:0]        io_in,
  output logic [1:0]        io_out,
  output logic [1:0]        io_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              cont_mode,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DATA,
    JEDEC,
    IGNORE
  } state_t;

  state_t              state_reg, state_next;
  state_t              eff_state;
  logic [3:0]          cnt_reg, cnt_next;
  logic [6:0]          shreg_reg, shreg_next;
  logic [21:0]         addr_sh_reg, addr_sh_next;
  logic [4:0]          jidx_reg, jidx_next;
  logic [1:0]          io_out_reg, io_out_next;
  logic [1:0]          oe_reg, oe_next;
  logic                mem_rd_reg, mem_rd_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic                cont_reg, cont_next;
  logic [7:0]          cmd_full;
  logic [23:0]         addr_full;

  assign cmd_full  = {shreg_reg, io_in[0]};
  assign addr_full = {addr_sh_reg, io_in};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      shreg_reg    <= 7'd0;
      addr_sh_reg  <= 22'd0;
      jidx_reg     <= 5'd0;
      io_out_reg   <= 2'b00;
      oe_reg       <= 2'b00;
      mem_rd_reg   <= 1'b0;
      mem_addr_reg <= '0;
      cont_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shreg_reg    <= shreg_next;
      addr_sh_reg  <= addr_sh_next;
      jidx_reg     <= jidx_next;
      io_out_reg   <= io_out_next;
      oe_reg       <= oe_next;
      mem_rd_reg   <= mem_rd_next;
      mem_addr_reg <= mem_addr_next;
      cont_reg     <= cont_next;
    end
  end

  always_comb begin
    // The IDLE edge is already the first CMD or ADDR edge (E0), so treat it as such.
    eff_state = state_reg;
    if (state_reg == IDLE) begin
      eff_state = cont_reg ? ADDR : CMD;
    end

    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shreg_next    = shreg_reg;
    addr_sh_next  = addr_sh_reg;
    jidx_next     = jidx_reg;
    io_out_next   = io_out_reg;
    oe_next       = oe_reg;
    mem_rd_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    cont_next     = cont_reg;

    if (cs_n) begin
      state_next  = IDLE;
      cnt_next    = 4'd0;
      oe_next     = 2'b00;
      io_out_next = 2'b00;
    end else begin
      case (eff_state)
        CMD: begin
          shreg_next = cmd_full[6:0];
          cnt_next   = cnt_reg + 4'd1;
          state_next = CMD;
          if (cnt_reg == 4'd7) begin
            cnt_next = 4'd0;
            if (cmd_full == 8'hBB) begin
              state_next = ADDR;
            end else if (cmd_full == 8'h9F) begin
              state_next  = JEDEC;
              oe_next     = 2'b10;
              io_out_next = {JEDEC_ID[23], 1'b0};
              jidx_next   = 5'd22;
            end else begin
              state_next = IGNORE;
            end
          end
        end

        ADDR: begin
          addr_sh_next = addr_full[21:0];
          cnt_next     = cnt_reg + 4'd1;
          state_next   = ADDR;
          if (cnt_reg == 4'd11) begin
            cnt_next      = 4'd0;
            state_next    = MODE;
            mem_addr_next = addr_full[ADDR_W-1:0];
            mem_rd_next   = 1'b1;
          end
        end

        MODE, DATA: begin
          cnt_next = cnt_reg + 4'd1;
          if (eff_state == MODE && cnt_reg == 4'd1) begin
            cont_next = (io_in == 2'b10);
          end
          if (eff_state == DATA) begin
            shreg_next  = {shreg_reg[4:0], 2'b00};
            io_out_next = shreg_reg[5:4];
          end
          // Byte boundary: take the prefetched byte and request the following one.
          if (cnt_reg == 4'd3) begin
            cnt_next      = 4'd0;
            state_next    = DATA;
            shreg_next    = {1'b0, mem_rdata[5:0]};
            io_out_next   = mem_rdata[7:6];
            oe_next       = 2'b11;
            mem_addr_next = mem_addr_reg + 1'b1;
            mem_rd_next   = 1'b1;
          end
        end

        JEDEC: begin
          io_out_next = {JEDEC_ID[jidx_reg], 1'b0};
          jidx_next   = (jidx_reg == 5'd0) ? 5'd23 : jidx_reg - 5'd1;
        end

        default: begin
          state_next = IGNORE;
        end
      endcase
    end
  end

  assign io_out    = io_out_reg;
  assign io_oe     = oe_reg & {2{~cs_n}};
  assign mem_rd    = mem_rd_reg;
  assign mem_addr  = mem_addr_reg;
  assign cont_mode = cont_reg;
  assign busy      = ~cs_n & (state_reg != IDLE) & (state_reg != IGNORE);

endmodule

// File: tb/tb_flash_dspi_responder.sv
// Bench for flash_dspi_responder: a dual-IO flash master plus a byte memory that
// answers 3 clocks after each read strobe, checked against a byte-level read model.
module tb_flash_dspi_responder;

  localparam logic [23:0] ID = 24'hEF4017;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cs_n = 1'b1;
  logic [1:0]  io_in = 2'b00;
  logic [1:0]  io_out;
  logic [1:0]  io_oe;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        cont_mode;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit cont_model = 1'b0;
  logic [7:0] mem [logic [23:0]];

  flash_dspi_responder #(.ADDR_W(24), .JEDEC_ID(ID)) dut (
    .clk(clk), .resetn(resetn), .cs_n(cs_n), .io_in(io_in), .io_out(io_out),
    .io_oe(io_oe), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cont_mode(cont_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Backing store: data appears 3 clocks after the strobe and holds until the next read.
  always begin
    logic [23:0] ra;
    @(posedge clk);
    #1;
    if (mem_rd === 1'b1) begin
      ra = mem_addr;
      repeat (3) @(posedge clk);
      #2;
      mem_rdata = mem.exists(ra) ? mem[ra] : 8'h00;
    end
  end

  task automatic clk_edge(input logic cs, input logic [1:0] io);
    @(negedge clk);
    cs_n  = cs;
    io_in = io;
    @(posedge clk);
    #1;
  endtask

  // Command (cold only), address and mode phases; returns the first data dibit.
  task automatic send_header(input logic [23:0] addr, input logic [7:0] mode,
                             input string name, output logic [1:0] first);
    logic [7:0]  cmd = 8'hBB;
    logic [23:0] nxt = addr + 24'd1;
    first = 2'b00;
    if (!cont_model) begin
      for (int i = 0; i < 8; i++) begin
        clk_edge(1'b0, {1'b0, cmd[7-i]});
        checks++;
        if ({mem_rd, io_oe, busy} !== 4'b0001) begin
          failures++;
          $display("FAIL %s cmd_edge%0d {rd,oe,busy}=%b required 0001", name, i, {mem_rd, io_oe, busy});
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      clk_edge(1'b0, addr[23-2*i -: 2]);
      checks++;
      if (mem_rd !== (i == 11) || io_oe !== 2'b00 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s addr_edge%0d rd=%b oe=%b busy=%b required rd=%b oe=00 busy=1",
                 name, i, mem_rd, io_oe, busy, (i == 11));
      end
    end
    checks++;
    if (mem_addr !== addr) begin
      failures++;
      $display("FAIL %s first_addr got %h required %h", name, mem_addr, addr);
    end
    for (int i = 0; i < 4; i++) begin
      clk_edge(1'b0, (i == 3) ? 2'($urandom_range(3)) : mode[7-2*i -: 2]);
      if (i == 1) begin
        cont_model = (mode[5:4] == 2'b10);
        checks++;
        if (cont_mode !== cont_model) begin
          failures++;
          $display("FAIL %s cont_mode got %b required %b", name, cont_mode, cont_model);
        end
      end
    end
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== nxt || io_oe !== 2'b11) begin
      failures++;
      $display("FAIL %s mode_end rd=%b addr=%h oe=%b required rd=1 addr=%h oe=11",
               name, mem_rd, mem_addr, io_oe, nxt);
    end
    first = io_out;
  endtask

  task automatic do_read(input logic [23:0] addr, input logic [7:0] mode, input int n, input string name);
    logic [1:0]  smp[$];
    logic [1:0]  s;
    logic [7:0]  got, exp;
    logic [23:0] ea;
    bit          was_cold = !cont_model;
    for (int k = 0; k <= n; k++) begin
      ea = addr + 24'(k);
      if (!mem.exists(ea)) mem[ea] = 8'($urandom);
    end
    send_header(addr, mode, name, s);
    smp.push_back(s);
    for (int j = 0; j < 4*n-1; j++) begin
      clk_edge(1'b0, 2'($urandom_range(3)));
      ea = addr + 24'(2 + j/4);
      checks++;
      if (mem_rd !== (j % 4 == 3) || io_oe !== 2'b11 || (mem_rd === 1'b1 && mem_addr !== ea)) begin
        failures++;
        $display("FAIL %s data_edge%0d rd=%b addr=%h oe=%b required rd=%b addr=%h oe=11",
                 name, j, mem_rd, mem_addr, io_oe, (j % 4 == 3), ea);
      end
      smp.push_back(io_out);
    end
    clk_edge(1'b1, 2'b00);
    checks++;
    if (io_oe !== 2'b00 || busy !== 1'b0 || cont_mode !== cont_model) begin
      failures++;
      $display("FAIL %s end oe=%b busy=%b cont=%b required oe=00 busy=0 cont=%b",
               name, io_oe, busy, cont_mode, cont_model);
    end
    for (int b = 0; b < n; b++) begin
      got = {smp[4*b], smp[4*b+1], smp[4*b+2], smp[4*b+3]};
      exp = mem[addr + 24'(b)];
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s byte%0d got %h required %h", name, b, got, exp);
      end
    end
    $display("read %s %s addr=%h mode=%h bytes=%0d", name, was_cold ? "cold" : "cont", addr, mode, n);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({io_out, io_oe, mem_rd, cont_mode, busy} !== 7'd0 || mem_addr !== 24'd0) begin
      failures++;
      $display("FAIL reset outputs got out=%b oe=%b rd=%b cont=%b busy=%b addr=%h required all zero",
               io_out, io_oe, mem_rd, cont_mode, busy, mem_addr);
    end
    @(negedge clk);
    resetn = 1'b1;
    clk_edge(1'b1, 2'b00);
    checks++;
    if (busy !== 1'b0 || io_oe !== 2'b00) begin
      failures++;
      $display("FAIL reset_release busy=%b oe=%b required 0 00", busy, io_oe);
    end
    $display("reset done");
  endtask

  task automatic test_cold_read;
    mem[24'h000010] = 8'hA5;
    do_read(24'h000010, 8'h20, 1, "t1");
  endtask

  task automatic test_cont_read;
    mem[24'h000020] = 8'h3C;
    do_read(24'h000020, 8'h20, 1, "t2");
  endtask

  task automatic test_wrap;
    do_read(24'hFFFFFF, 8'h2A, 3, "t3_wrap");
  endtask

  task automatic test_exit_cont;
    for (int i = 0; i < 16; i++) begin
      clk_edge(1'b0, 2'b11);
      if (i < 15) begin
        checks++;
        if (io_oe !== 2'b00) begin
          failures++;
          $display("FAIL exit_cont edge%0d oe=%b required 00", i, io_oe);
        end
      end
    end
    clk_edge(1'b1, 2'b00);
    cont_model = 1'b0;
    checks++;
    if (cont_mode !== 1'b0 || io_oe !== 2'b00) begin
      failures++;
      $display("FAIL exit_cont cont=%b oe=%b required 0 00", cont_mode, io_oe);
    end
    $display("exit from continuous mode");
    do_read(24'($urandom), 8'h00, 2, "t4_after_exit");
  endtask

  task automatic test_exit_cold;
    for (int i = 0; i < 16; i++) begin
      clk_edge(1'b0, 2'b11);
      checks++;
      if (io_oe !== 2'b00 || mem_rd !== 1'b0 || busy !== (i < 7)) begin
        failures++;
        $display("FAIL exit_cold edge%0d oe=%b rd=%b busy=%b required 00 0 %b", i, io_oe, mem_rd, busy, (i < 7));
      end
    end
    clk_edge(1'b1, 2'b00);
    $display("exit sequence outside continuous mode");
    do_read(24'($urandom), 8'h10, 1, "after_exit_cold");
  endtask

  task automatic test_jedec;
    logic [7:0]  cmd = 8'h9F;
    logic [47:0] exp = {ID, ID};
    logic [47:0] got = '0;
    for (int i = 0; i < 8; i++) clk_edge(1'b0, {1'b0, cmd[7-i]});
    for (int k = 0; k < 48; k++) begin
      if (k > 0) clk_edge(1'b0, 2'b00);
      got[47-k] = io_out[1];
      checks++;
      if (io_oe !== 2'b10) begin
        failures++;
        $display("FAIL jedec_oe bit%0d got %b required 10", k, io_oe);
      end
    end
    clk_edge(1'b1, 2'b00);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL jedec_stream got %h required %h", got, exp);
    end
    $display("jedec stream %h", got);
  endtask

  task automatic test_aborts;
    logic [7:0]  cmd = 8'hBB;
    logic [23:0] a = 24'h5A5A5A;
    logic [1:0]  s;
    // Cold abort just before E15 (address phase).
    for (int i = 0; i < 15; i++) begin
      clk_edge(1'b0, (i < 8) ? {1'b0, cmd[7-i]} : a[23-2*(i-8) -: 2]);
    end
    clk_edge(1'b1, 2'b00);
    checks++;
    if (io_oe !== 2'b00 || mem_rd !== 1'b0 || cont_mode !== cont_model) begin
      failures++;
      $display("FAIL abort_e15 oe=%b rd=%b cont=%b required 00 0 %b", io_oe, mem_rd, cont_mode, cont_model);
    end
    $display("abort at E15");
    // Arm continuous mode, then abort before M[5:4] is captured.
    do_read(24'($urandom), 8'hA5, 1, "t6_arm");
    for (int i = 0; i < 5; i++) clk_edge(1'b0, 2'($urandom_range(3)));
    clk_edge(1'b1, 2'b00);
    checks++;
    if (cont_mode !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_cont cont=%b rd=%b busy=%b required 1 0 0", cont_mode, mem_rd, busy);
    end
    do_read(24'($urandom), 8'h20, 1, "t6_resume");
    // Deselect during DATA: pads release before the next edge.
    send_header(24'h001234, 8'h20, "t6_data_abort", s);
    clk_edge(1'b0, 2'b00);
    @(negedge clk);
    cs_n = 1'b1;
    #1;
    checks++;
    if (io_oe !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_data_comb oe=%b busy=%b required 00 0", io_oe, busy);
    end
    @(posedge clk);
    #1;
    $display("abort during data");
    // Asynchronous reset during DATA.
    send_header(24'h00ABCD, 8'h20, "t6_reset", s);
    clk_edge(1'b0, 2'b00);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({io_out, io_oe, mem_rd, cont_mode, busy} !== 7'd0 || mem_addr !== 24'd0) begin
      failures++;
      $display("FAIL reset_mid_data out=%b oe=%b rd=%b cont=%b busy=%b addr=%h required all zero",
               io_out, io_oe, mem_rd, cont_mode, busy, mem_addr);
    end
    cont_model = 1'b0;
    @(negedge clk);
    cs_n = 1'b1;
    resetn = 1'b1;
    clk_edge(1'b1, 2'b00);
    $display("reset during data");
  endtask

  task automatic test_random;
    logic [7:0] mode;
    for (int t = 0; t < 8; t++) begin
      mode = 8'($urandom);
      if ($urandom_range(1) == 1) mode[5:4] = 2'b10;
      do_read(24'($urandom), mode, int'($urandom_range(1, 4)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_cont_read();
    test_wrap();
    test_exit_cont();
    test_jedec();
    test_aborts();
    test_random();
    if (cont_model) test_exit_cont();
    test_exit_cold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
